seg_scan_ctrl: RTL

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display that shares the single combinational hex-to-segment decoder across all digits. Each digit slot presents one nibble to the shared decoder and asserts the matching anode. The block double-buffers the displayed 16-bit value so that updates take effect only at frame boundaries, which prevents tearing. It sits between the system datapath (value producer) and the board display pins; the decoder's 7-bit output drives the cathodes directly.

---
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Double-buffers the displayed value so updates only land on frame boundaries.
module seg_scan_ctrl #(
   parameter int ON_CYCLES  = 100000,
   parameter int GAP_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic        lzb,
   output logic [3:0]  hex_out,
   output logic [3:0]  an,
   output logic        dp,
   output logic        pending,
   output logic        frame_tick
);

   localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {S_OFF, S_ON, S_GAP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    idx, idx_n;
   logic          boundary;
   logic          commit;
   logic          blank;
   logic [15:0]   shadow, active;
   logic [3:0]    dps, dpa;
   logic [3:0]    hex_n, an_n;
   logic          dp_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_OFF;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
      end
   end

   // Boundary marks the last cycle of digit 3's slot; dropping en abandons the frame silently.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = idx;
      boundary = 1'b0;
      case (state)
         S_OFF: begin
            cnt_n = '0;
            idx_n = '0;
            state_n = S_ON;
         end
         S_ON: begin
            if (cnt == ON_LAST) begin
               cnt_n = '0;
               if (GAP_CYCLES == 0) begin
                  idx_n    = idx + 2'd1;
                  boundary = (idx == 2'd3);
               end else begin
                  state_n = S_GAP;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_n    = '0;
               state_n  = S_ON;
               idx_n    = idx + 2'd1;
               boundary = (idx == 2'd3);
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = S_OFF;
      endcase
      if (!en) begin
         state_n  = S_OFF;
         cnt_n    = '0;
         idx_n    = '0;
         boundary = 1'b0;
      end
   end

   assign commit = (state == S_OFF) || boundary;

   // A load coinciding with a commit goes straight through to the active buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow  <= '0;
         dps     <= '0;
         active  <= '0;
         dpa     <= '0;
         pending <= 1'b0;
      end else begin
         if (load) begin
            shadow <= value_in;
            dps    <= dp_in;
         end
         if (commit) begin
            active  <= load ? value_in : shadow;
            dpa     <= load ? dp_in : dps;
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   always_comb begin
      blank = 1'b0;
      case (idx)
         2'd1:    blank = (active[15:4] == 12'd0);
         2'd2:    blank = (active[15:8] == 8'd0);
         2'd3:    blank = (active[15:12] == 4'd0);
         default: blank = 1'b0;
      endcase
      blank = blank && lzb;
      hex_n = active[{idx, 2'b00} +: 4];
      an_n  = 4'hF;
      dp_n  = 1'b1;
      if (state == S_ON && !blank) begin
         an_n = ~(4'b0001 << idx);
         dp_n = ~dpa[idx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hex_out    <= '0;
         an         <= 4'hF;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         hex_out    <= hex_n;
         an         <= an_n;
         dp         <= dp_n;
         frame_tick <= boundary;
      end
   end

endmodule
